// File: rtl/mycpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control FSM.
// Holds the state encoding, the decoded instruction class and the
// priority decoder that maps the raw class flags onto a single class.
package mycpu_ctrl_pkg;

  // Default width of the optional performance counters.
  localparam int unsigned PERF_W_DEFAULT = 32;

  // FSM state encoding; the numeric values are visible on the state port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_e;

  // Instruction class captured in DECODE and held until the next DECODE.
  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } cls_e;

  // Resolve conflicting flags: branch wins over store, store over load,
  // load over a plain register write.
  function automatic cls_e decode_cls(input logic is_branch,
                                      input logic is_store,
                                      input logic is_load,
                                      input logic reg_write);
    if (is_branch)      return CLS_BRANCH;
    else if (is_store)  return CLS_STORE;
    else if (is_load)   return CLS_LOAD;
    else if (reg_write) return CLS_ALU;
    else                return CLS_NONE;
  endfunction

endpackage

// File: rtl/mycpu_perf_cnt.sv
// Free-running event counter with enable; wraps modulo 2^W.
// Only instantiated when MYCPU_CTRL_PERF_EN is defined.
module mycpu_perf_cnt
  import mycpu_ctrl_pkg::*;
#(
  parameter int unsigned W = PERF_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count one event per enabled cycle; natural overflow gives the wrap.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mycpu_ctrl_fsm.sv
// Control FSM for a simple multi-cycle CPU:
//   IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH ...
// The instruction class is latched once in DECODE; later flag changes
// have no effect. Request strobes (inst_req, data_req, data_wr) decode
// from registered state only, so no ack reaches them combinationally.
// Optional performance counters are built when MYCPU_CTRL_PERF_EN is
// defined; without it the counter ports and logic are absent.
module mycpu_ctrl_fsm
  import mycpu_ctrl_pkg::*;
#(
  parameter int unsigned PERF_W = PERF_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch handshake
  output logic              inst_req,
  input  logic              inst_ack,
  // decoded instruction class
  input  logic              is_branch,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              reg_write,
  input  logic              branch_taken,
  // data memory handshake
  output logic              data_req,
  output logic              data_wr,
  input  logic              data_ack,
  // datapath controls
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              ir_en,
  output logic              rf_wen,
  output logic              wb_sel_mem,
  output logic              retire,
  output logic [2:0]        state
`ifdef MYCPU_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] cycle_cnt,
  output logic [PERF_W-1:0] retire_cnt
`endif
);

  state_e state_q, state_d;
  cls_e   cls_q, cls_d;

  assign state = state_q;

  // State and latched instruction class; reset drops any pending request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d       = state_q;
    cls_d         = cls_q;
    inst_req      = 1'b0;
    ir_en         = 1'b0;
    data_req      = 1'b0;
    data_wr       = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    rf_wen        = 1'b0;
    wb_sel_mem    = 1'b0;
    retire        = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        inst_req = 1'b1;
        if (inst_ack) begin
          ir_en   = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        cls_d   = decode_cls(is_branch, is_store, is_load, reg_write);
        state_d = EXEC;
      end

      EXEC: begin
        case (cls_q)
          CLS_BRANCH: begin
            pc_en         = 1'b1;
            pc_sel_branch = branch_taken;
            retire        = 1'b1;
            state_d       = FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d = MEM;
          end
          CLS_ALU: begin
            state_d = WB;
          end
          default: begin
            // No class flag: behaves as a no-op that still advances the PC.
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
        endcase
      end

      MEM: begin
        data_req = 1'b1;
        data_wr  = (cls_q == CLS_STORE);
        if (data_ack) begin
          if (cls_q == CLS_STORE) begin
            pc_en   = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end

      WB: begin
        rf_wen     = 1'b1;
        wb_sel_mem = (cls_q == CLS_LOAD);
        pc_en      = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef MYCPU_CTRL_PERF_EN
  logic busy;
  assign busy = (state_q != IDLE);

  mycpu_perf_cnt #(.W(PERF_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (busy),
    .count (cycle_cnt)
  );

  mycpu_perf_cnt #(.W(PERF_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (retire),
    .count (retire_cnt)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule
